// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack channel between the fetch stage and imem.
// One outstanding request; ack may arrive in the same cycle req rises.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, imem req/ack handshake, stall hold
// and redirect handling, feeding the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clk_en,
  input  logic               i_stall_f,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  fetch_stage_if.master      imem,
  output logic [31:0]        o_instr_f,
  output logic [31:0]        o_pc_p4_f,
  output logic [31:0]        o_pc_f,
  output logic               o_fetch_wait
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc_p4;

  logic [31:0] pc_p4;
  logic [31:0] tgt;
  logic        vld;
  logic [31:0] instr;
  logic [31:0] instr_p4;
  logic        req;
  logic [31:0] addr;

  assign pc_p4 = r_pc + 32'd4;
  assign tgt   = {i_redirect_pc[31:2], 2'b00};

  always_comb begin
    req      = 1'b0;
    addr     = r_pc;
    vld      = 1'b0;
    instr    = 32'h0;
    instr_p4 = 32'h0;
    case (r_state)
      S_FETCH: begin
        req = 1'b1;
        if (imem.ack && !i_redirect) begin
          vld      = 1'b1;
          instr    = imem.rdata;
          instr_p4 = pc_p4;
        end
      end
      S_HOLD: begin
        if (!i_redirect) begin
          vld      = 1'b1;
          instr    = r_hold_instr;
          instr_p4 = r_hold_pc_p4;
        end
      end
      // Stale request keeps its original address until memory acks it.
      S_DISCARD: begin
        req  = 1'b1;
        addr = r_req_addr;
      end
      default: ;
    endcase
    if (i_rst) begin
      req      = 1'b0;
      addr     = 32'h0;
      vld      = 1'b0;
      instr    = 32'h0;
      instr_p4 = 32'h0;
    end
  end

  assign imem.req     = req;
  assign imem.addr    = addr;
  assign o_instr_f    = instr;
  assign o_pc_p4_f    = instr_p4;
  assign o_fetch_wait = ~vld;
  assign o_pc_f       = i_rst ? RESET_PC : r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= 32'h0;
      r_hold_instr <= 32'h0;
      r_hold_pc_p4 <= 32'h0;
    end else if (i_clk_en) begin
      case (r_state)
        S_FETCH: begin
          if (i_redirect) begin
            r_pc <= tgt;
            if (!imem.ack) begin
              r_req_addr <= r_pc;
              r_state    <= S_DISCARD;
            end
          end else if (imem.ack) begin
            r_pc <= pc_p4;
            if (i_stall_f) begin
              r_hold_instr <= imem.rdata;
              r_hold_pc_p4 <= pc_p4;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (i_redirect) begin
            r_pc         <= tgt;
            r_hold_instr <= 32'h0;
            r_hold_pc_p4 <= 32'h0;
            r_state      <= S_FETCH;
          end else if (!i_stall_f) begin
            r_state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (i_redirect) r_pc <= tgt;
          if (imem.ack)   r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
